floating_point_subtractor: RTL and testbench
============================================

FLOATING_POINT_SUBTRACTOR -- requirements
Module: floating_point_Subtractor

Interface
REQ-001 SHALL have these ports, one per line, in this order: name  direction  width  meaning.
REQ-002 CLK  input  1  clock; all state changes occur on the rising edge.
REQ-003 nRST  input  1  reset; synchronous, active-low.
REQ-004 St  input  1  start request; sampled only in IDLE.
REQ-005 F1  input  5  minuend fraction; two's complement S.FFFF, range -1 to +15/16.
REQ-006 F2  input  5  subtrahend fraction; same format as F1.
REQ-007 E1  input  4  minuend exponent; two's complement, range -8 to +7.
REQ-008 E2  input  4  subtrahend exponent; same format as E1.
REQ-009 Fnorm  output  5  normalized result fraction.
REQ-010 Enorm  output  4  result exponent.
REQ-011 V  output  1  exponent overflow flag.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 Operand value SHALL be F x 2^E; the result SHALL be F1*2^E1 - F2*2^E2.
REQ-014 The block SHALL have no parameters.

Function
REQ-015 FSM states SHALL be IDLE, ALIGN, ADD, NORM and DONE.
REQ-016 IDLE with St=1: latch A = sign-extend6(F1) and EA = E1; latch B = -sign-extend6(F2) and EB = E2; clear V; go to ALIGN.
REQ-017 The negation SHALL use 6 bits, so F2=10000 (-1) yields B=010000 (+1).
REQ-018 St SHALL be ignored outside IDLE.
REQ-019 ALIGN, A==0: set EA = EB and go to ADD.
REQ-020 ALIGN, B==0: go to ADD.
REQ-021 ALIGN, EA<EB (signed): arithmetic-shift A right 1 bit and increment EA, one step per cycle.
REQ-022 ALIGN, EA>EB (signed): arithmetic-shift B right 1 bit and increment EB, one step per cycle.
REQ-023 ALIGN, EA==EB: go to ADD.
REQ-024 Bits shifted out during alignment SHALL be truncated.
REQ-025 ADD: S = A + B (6-bit, cannot overflow); E = EA; go to NORM.
REQ-026 NORM, S==0: Fnorm=00000, Enorm=1000, V=0; go to DONE.
REQ-027 NORM, S[5]!=S[4]: arithmetic-shift S right 1 and increment E (one cycle).
REQ-028 NORM right-shift with E=0111 SHALL set V=1, Fnorm=00000, Enorm=0000; go to DONE.
REQ-029 NORM, S[4]==S[3]: shift S left 1 and decrement E, one bit per cycle.
REQ-030 NORM left-shift with E=1000 (underflow) SHALL force Fnorm=00000, Enorm=1000, V=0; go to DONE.
REQ-031 NORM, S[4]!=S[3]: Fnorm = S[4:0], Enorm = E; go to DONE.
REQ-032 Thus 11000 normalizes to 10000 with E-1.
REQ-033 DONE SHALL assert Done=1 for exactly one cycle, then go to IDLE.
REQ-034 Fnorm, Enorm and V SHALL hold their values until the next accepted St.
REQ-035 Latency from the St-sampling edge SHALL be 1 (load) + alignment steps (at most 15) + 1 (add) + normalize steps (at most 5) + 1 (DONE) cycles.
REQ-036 St held high through DONE SHALL start a new operation on the first IDLE cycle.

Reset
REQ-037 nRST=0 at a rising edge SHALL force IDLE.
REQ-038 nRST=0 SHALL clear Fnorm, Enorm, V, Done and all internal registers to 0 from any state, including mid-operation.
REQ-039 nRST=0 SHALL take priority over St.
REQ-040 After reset release, the block SHALL accept St on the first edge.

Verification
REQ-041 F1=01010 E1=1001, F2=01100 E2=1010 -> Fnorm=10010, Enorm=1001, V=0, Done pulse.
REQ-042 F1=01010 E1=1001, F2=00000 E2=1000 -> Fnorm=01010, Enorm=1001, V=0.
REQ-043 F1=F2=01010, E1=E2=0101 -> Fnorm=00000, Enorm=1000, V=0.
REQ-044 F1=00100 E1=0000, F2=01100 E2=0000 -> Fnorm=10000, Enorm=1111.
REQ-045 Bench SHALL cover these further directed scenarios:
- F1=01000 E1=0111, F2=10000 E2=0110 -> V=1, Fnorm=00000, Enorm=0000.
- F1=01000 E1=1000, F2=00110 E2=1000 -> underflow, Fnorm=00000, Enorm=1000, V=0.
- nRST=0 during ALIGN -> next cycle all outputs 0, state IDLE, no Done pulse.

Source files
------------

// File: rtl/floating_point_subtractor.sv
// floating_point_subtractor: sequential F1*2^E1 - F2*2^E2 via align/add/normalize FSM
// Ports: CLK clock; nRST sync active-low reset; St start (sampled in IDLE);
//        F1/F2 5-bit two's complement fractions S.FFFF; E1/E2 4-bit two's complement exponents;
//        Fnorm/Enorm normalized result; V exponent overflow; Done one-cycle completion pulse.
module floating_point_subtractor (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       St,
  input  logic [4:0] F1,
  input  logic [4:0] F2,
  input  logic [3:0] E1,
  input  logic [3:0] E2,
  output logic [4:0] Fnorm,
  output logic [3:0] Enorm,
  output logic       V,
  output logic       Done
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, state_next;
  logic [5:0] a, b, s;
  logic [3:0] ea, eb, e;
  logic ea_lt, ea_gt, ovf, lsh;
  assign ea_lt = $signed(ea) < $signed(eb);
  assign ea_gt = $signed(ea) > $signed(eb);
  // sum spills into the sign-extension bit: needs one right shift
  assign ovf = s[5] != s[4];
  // redundant sign bit below the fraction sign: needs a left shift
  assign lsh = s[4] == s[3];
  assign Done = state == DONE;
  always_ff @(posedge CLK)
    if (!nRST) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = St ? ALIGN : IDLE;
      ALIGN: state_next = (a == '0 || b == '0 || ea == eb) ? ADD : ALIGN;
      ADD:   state_next = NORM;
      NORM:  state_next = (s == '0 || (ovf && e == 4'b0111) || (!ovf && (!lsh || e == 4'b1000))) ? DONE : NORM;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      a <= '0;
      b <= '0;
      s <= '0;
      ea <= '0;
      eb <= '0;
      e <= '0;
      Fnorm <= '0;
      Enorm <= '0;
      V <= 1'b0;
    end else
      case (state)
        IDLE:
          if (St) begin
            a <= {F1[4], F1};
            // 6-bit negation so that -(-1) is representable as +1
            b <= -{F2[4], F2};
            ea <= E1;
            eb <= E2;
            V <= 1'b0;
          end
        ALIGN:
          if (a == '0) ea <= eb;
          else if (b != '0 && ea_lt) begin
            a <= {a[5], a[5:1]};
            ea <= ea + 4'd1;
          end else if (b != '0 && ea_gt) begin
            b <= {b[5], b[5:1]};
            eb <= eb + 4'd1;
          end
        ADD: begin
          s <= a + b;
          e <= ea;
        end
        NORM:
          if (s == '0) begin
            Fnorm <= '0;
            Enorm <= 4'b1000;
            V <= 1'b0;
          end else if (ovf) begin
            if (e == 4'b0111) begin
              Fnorm <= '0;
              Enorm <= '0;
              V <= 1'b1;
            end else begin
              s <= {s[5], s[5:1]};
              e <= e + 4'd1;
            end
          end else if (lsh) begin
            // exponent already at its minimum: flush to zero
            if (e == 4'b1000) begin
              Fnorm <= '0;
              Enorm <= 4'b1000;
              V <= 1'b0;
            end else begin
              s <= {s[4:0], 1'b0};
              e <= e - 4'd1;
            end
          end else begin
            Fnorm <= s[4:0];
            Enorm <= e;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_floating_point_subtractor.sv
// tb_floating_point_subtractor: directed self-checking bench for floating_point_subtractor
module tb_floating_point_subtractor;
  logic CLK = 1'b0;
  logic nRST, St, V, Done;
  logic [4:0] F1, F2, Fnorm;
  logic [3:0] E1, E2, Enorm;
  int checks = 0;
  int errors = 0;

  floating_point_subtractor dut (
    .CLK(CLK), .nRST(nRST), .St(St), .F1(F1), .F2(F2), .E1(E1), .E2(E2),
    .Fnorm(Fnorm), .Enorm(Enorm), .V(V), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (Done !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, " done"}, 8'(Done), 8'd1);
  endtask

  task automatic check_out(input string tag, input logic [4:0] xf, input logic [3:0] xe, input logic xv);
    chk({tag, " Fnorm"}, 8'(Fnorm), 8'(xf));
    chk({tag, " Enorm"}, 8'(Enorm), 8'(xe));
    chk({tag, " V"}, 8'(V), 8'(xv));
  endtask

  // Called at a negedge; returns at a negedge one cycle after the Done pulse.
  task automatic run(input logic [4:0] f1, input logic [3:0] e1, input logic [4:0] f2, input logic [3:0] e2,
                     input logic [4:0] xf, input logic [3:0] xe, input logic xv, input string tag);
    F1 = f1; E1 = e1; F2 = f2; E2 = e2; St = 1'b1;
    @(negedge CLK);
    St = 1'b0;
    F1 = ~f1; E1 = ~e1; F2 = ~f2; E2 = ~e2;
    wait_done(tag);
    check_out(tag, xf, xe, xv);
    @(negedge CLK);
    chk({tag, " pulse"}, 8'(Done), 8'd0);
    chk({tag, " hold"}, 8'(Fnorm), 8'(xf));
  endtask

  initial begin
    nRST = 1'b0; St = 1'b1; F1 = '1; F2 = '1; E1 = '1; E2 = '1;
    @(negedge CLK);
    @(negedge CLK);
    check_out("reset", 5'b00000, 4'b0000, 1'b0);
    chk("reset Done", 8'(Done), 8'd0);
    nRST = 1'b1; St = 1'b0;
    run(5'b01010, 4'b1001, 5'b01100, 4'b1010, 5'b10010, 4'b1001, 1'b0, "align_a");
    run(5'b01010, 4'b1001, 5'b00000, 4'b1000, 5'b01010, 4'b1001, 1'b0, "b_zero");
    run(5'b01010, 4'b0101, 5'b01010, 4'b0101, 5'b00000, 4'b1000, 1'b0, "zero_sum");
    run(5'b00100, 4'b0000, 5'b01100, 4'b0000, 5'b10000, 4'b1111, 1'b0, "norm_left");
    run(5'b01000, 4'b0111, 5'b10000, 4'b0110, 5'b00000, 4'b0000, 1'b1, "overflow");
    run(5'b01000, 4'b1000, 5'b00110, 4'b1000, 5'b00000, 4'b1000, 1'b0, "underflow");
    run(5'b01000, 4'b0000, 5'b11000, 4'b0000, 5'b01000, 4'b0001, 1'b0, "norm_right");
    run(5'b00000, 4'b0011, 5'b10000, 4'b0010, 5'b01000, 4'b0011, 1'b0, "a_zero_neg1");
    // St held high through DONE restarts on the first IDLE cycle with the inputs present then
    F1 = 5'b01010; E1 = 4'b1001; F2 = 5'b00000; E2 = 4'b1000; St = 1'b1;
    wait_done("held1");
    check_out("held1", 5'b01010, 4'b1001, 1'b0);
    F1 = 5'b01010; E1 = 4'b0101; F2 = 5'b01010; E2 = 4'b0101;
    @(negedge CLK);
    @(negedge CLK);
    St = 1'b0;
    chk("held2 pending", 8'(Done), 8'd0);
    wait_done("held2");
    check_out("held2", 5'b00000, 4'b1000, 1'b0);
    @(negedge CLK);
    run(5'b01010, 4'b1001, 5'b01100, 4'b1010, 5'b10010, 4'b1001, 1'b0, "pre_reset");
    // long alignment (EA=-8, EB=7), reset two cycles in
    F1 = 5'b01000; E1 = 4'b1000; F2 = 5'b01000; E2 = 4'b0111; St = 1'b1;
    @(negedge CLK);
    St = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    check_out("mid_reset", 5'b00000, 4'b0000, 1'b0);
    chk("mid_reset Done", 8'(Done), 8'd0);
    // accept St on the very first edge after release
    nRST = 1'b1;
    run(5'b00100, 4'b0000, 5'b01100, 4'b0000, 5'b10000, 4'b1111, 1'b0, "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
